// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Shared opcodes, FSM state encoding and width helper for the
//             registered sequential ALU (alu_seq).
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode map; 12..15 are unimplemented and flagged as illegal
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_XNOR = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SAR  = 4'd11;

    // Control FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Ceiling log2, evaluated at elaboration for shift-amount / counter widths
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_if
//  Purpose  : Operation-issue and result handshake bundle for alu_seq.
//             master = operand producer / result consumer side,
//             slave  = the ALU itself.
//  Revision : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int WIDTH = 8
);
    // Request channel
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [3:0]         op;

    // Result channel
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] y;
    logic               zero;
    logic               carry;
    logic               ovf;
    logic               neg;
    logic               illegal;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, y, zero, carry, ovf, neg, illegal
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, y, zero, carry, ovf, neg, illegal
    );

endinterface : alu_seq_if
`default_nettype wire

// File: rtl/alu_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_mul
//  Purpose  : Iterative unsigned shift-add multiplier, one partial product
//             per clock over WIDTH steps. 'done' is high during the final
//             step and 'p' then carries the complete product, so the parent
//             can capture it on that same edge.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_mul
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               start,
    input  wire logic [WIDTH-1:0]   a,
    input  wire logic [WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*WIDTH-1:0]      p
);

    localparam int              c_cnt_w = clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

    logic                   r_busy;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic [2*WIDTH-1:0]     w_step_sum;

    // Accumulator after adding this step's partial product
    always_comb begin
        w_step_sum = r_acc + (r_mplier[0] ? r_mcand : '0);
    end

    assign done = r_busy && (r_cnt == c_last);
    assign p    = w_step_sum;

    // Operand latch on start, then one shift-add step per cycle until the last
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
        end else if (r_busy) begin
            r_acc    <= w_step_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule : alu_seq_mul
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq
//  Purpose  : Registered WIDTH-bit ALU with valid/ready handshakes, double-
//             width result and status flags. Single-cycle ops complete on the
//             accept edge; MUL runs the iterative multiplier for WIDTH steps.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    alu_seq_if.slave    bus
);

    localparam int c_sw = clog2(WIDTH);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;

    logic [2*WIDTH-1:0]     r_y;
    logic                   r_zero;
    logic                   r_carry;
    logic                   r_ovf;
    logic                   r_neg;
    logic                   r_illegal;

    logic                   w_in_ready;
    logic                   w_out_valid;
    logic                   w_accept;
    logic                   w_is_mul;
    logic                   w_mul_start;
    logic                   w_mul_done;
    logic [2*WIDTH-1:0]     w_mul_p;

    logic [c_sw-1:0]        w_shamt;
    logic [WIDTH:0]         w_add_full;
    logic [WIDTH-1:0]       w_sub;
    logic [WIDTH-1:0]       w_sar;
    logic [2*WIDTH-1:0]     w_res;
    logic                   w_carry;
    logic                   w_ovf;
    logic                   w_neg_en;
    logic                   w_neg;
    logic                   w_illegal;

    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_is_mul    = (bus.op == OP_MUL);
    assign w_mul_start = w_accept && w_is_mul;

    assign w_shamt     = bus.b[c_sw-1:0];
    assign w_add_full  = {1'b0, bus.a} + {1'b0, bus.b};
    assign w_sub       = bus.a - bus.b;
    assign w_sar       = WIDTH'($signed(bus.a) >>> w_shamt);

    alu_seq_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (w_mul_start),
        .a     (bus.a),
        .b     (bus.b),
        .done  (w_mul_done),
        .p     (w_mul_p)
    );

    // Single-cycle datapath: result and flags for every non-MUL opcode
    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_neg_en  = 1'b1;
        w_illegal = 1'b0;
        case (bus.op)
            OP_ADD: begin
                w_res   = {{(WIDTH-1){1'b0}}, w_add_full};
                w_carry = w_add_full[WIDTH];
                w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (w_add_full[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res   = {{WIDTH{1'b0}}, w_sub};
                w_carry = (bus.a < bus.b);
                w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  w_res = {{WIDTH{1'b0}},   bus.a & bus.b};
            OP_NAND: w_res = {{WIDTH{1'b0}}, ~(bus.a & bus.b)};
            OP_OR:   w_res = {{WIDTH{1'b0}},   bus.a | bus.b};
            OP_NOR:  w_res = {{WIDTH{1'b0}}, ~(bus.a | bus.b)};
            OP_XOR:  w_res = {{WIDTH{1'b0}},   bus.a ^ bus.b};
            OP_XNOR: w_res = {{WIDTH{1'b0}}, ~(bus.a ^ bus.b)};
            OP_MUL: begin
                // Result comes from the multiplier later; sign flag unused
                w_neg_en = 1'b0;
            end
            OP_SHL: begin
                w_res    = {{WIDTH{1'b0}}, bus.a} << w_shamt;
                w_neg_en = 1'b0;
            end
            OP_SHR:  w_res = {{WIDTH{1'b0}}, bus.a >> w_shamt};
            OP_SAR:  w_res = {{WIDTH{1'b0}}, w_sar};
            default: begin
                w_illegal = 1'b1;
                w_neg_en  = 1'b0;
            end
        endcase
        w_neg = w_neg_en && w_res[WIDTH-1];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_state_next = w_is_mul ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (w_mul_done) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: accept only when idle, present result only when done
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE:  w_in_ready  = 1'b1;
            S_DONE:  w_out_valid = 1'b1;
            default: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    // Result/flag capture: single-cycle ops on accept, MUL on its final step
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y       <= '0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_ovf     <= 1'b0;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_y       <= w_res;
            r_zero    <= (w_res == '0);
            r_carry   <= w_carry;
            r_ovf     <= w_ovf;
            r_neg     <= w_neg;
            r_illegal <= w_illegal;
        end else if ((r_state == S_MUL) && w_mul_done) begin
            r_y       <= w_mul_p;
            r_zero    <= (w_mul_p == '0);
            r_carry   <= |w_mul_p[2*WIDTH-1:WIDTH];
            r_ovf     <= 1'b0;
            r_neg     <= 1'b0;
            r_illegal <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_y;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.ovf       = r_ovf;
    assign bus.neg       = r_neg;
    assign bus.illegal   = r_illegal;

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq
//  Purpose  : Directed self-checking bench for alu_seq (WIDTH = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   lat;
    int   hits;

    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for in_ready, present one request, drop in_valid after the accept edge
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("issue_timeout", 32'(bus.in_ready), 32'd1);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Count clocks from accept until out_valid; in_ready must stay low meanwhile
    task automatic wait_valid(output int cycles);
        cycles = 1;
        while (bus.out_valid !== 1'b1 && cycles < 40) begin
            check("busy_in_ready", 32'(bus.in_ready), 32'd0);
            bus.a  = 8'h00;
            bus.b  = 8'h00;
            bus.op = OP_ADD;
            tick();
            cycles++;
        end
    endtask

    task automatic expect_res(input string tag, input logic [15:0] y, input logic z,
                              input logic c, input logic o, input logic n, input logic il);
        check($sformatf("%s.valid", tag),   32'(bus.out_valid), 32'd1);
        check($sformatf("%s.y", tag),       32'(bus.y),         32'(y));
        check($sformatf("%s.zero", tag),    32'(bus.zero),      32'(z));
        check($sformatf("%s.carry", tag),   32'(bus.carry),     32'(c));
        check($sformatf("%s.ovf", tag),     32'(bus.ovf),       32'(o));
        check($sformatf("%s.neg", tag),     32'(bus.neg),       32'(n));
        check($sformatf("%s.illegal", tag), 32'(bus.illegal),   32'(il));
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // Full transaction: issue, check latency and result, then release it
    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int exp_lat, input logic [15:0] y,
                       input logic z, input logic c, input logic o, input logic n,
                       input logic il);
        int l;
        do_op(op, a, b);
        wait_valid(l);
        check($sformatf("%s.latency", tag), 32'(l), 32'(exp_lat));
        check($sformatf("%s.in_ready_done", tag), 32'(bus.in_ready), 32'd0);
        expect_res(tag, y, z, c, o, n, il);
        consume();
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst.in_ready",  32'(bus.in_ready),  32'd1);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check("rst.y",         32'(bus.y),         32'd0);
        check("rst.flags",     32'({bus.zero, bus.carry, bus.ovf, bus.neg, bus.illegal}), 32'd0);

        //   tag           op       a      b      lat  y          z  c  o  n  il
        run("add_carry",  OP_ADD,  8'hF0, 8'h20, 1, 16'h0110, 0, 1, 0, 0, 0);
        run("add_ovf",    OP_ADD,  8'h7F, 8'h01, 1, 16'h0080, 0, 0, 1, 1, 0);
        run("sub_ovf",    OP_SUB,  8'h80, 8'h01, 1, 16'h007F, 0, 0, 1, 0, 0);
        run("sub_borrow", OP_SUB,  8'h03, 8'h05, 1, 16'h00FE, 0, 1, 0, 1, 0);
        run("nand",       OP_NAND, 8'h0F, 8'h33, 1, 16'h00FC, 0, 0, 0, 1, 0);
        run("xnor_zero",  OP_XNOR, 8'h0F, 8'hF0, 1, 16'h0000, 1, 0, 0, 0, 0);
        run("or",         OP_OR,   8'h50, 8'h05, 1, 16'h0055, 0, 0, 0, 0, 0);
        run("mul_ff",     OP_MUL,  8'hFF, 8'hFF, 9, 16'hFE01, 0, 1, 0, 0, 0);
        run("mul_zero",   OP_MUL,  8'h37, 8'h00, 9, 16'h0000, 1, 0, 0, 0, 0);
        run("mul_small",  OP_MUL,  8'h0C, 8'h0A, 9, 16'h0078, 0, 0, 0, 0, 0);
        run("sar3",       OP_SAR,  8'h90, 8'h03, 1, 16'h00F2, 0, 0, 0, 1, 0);
        run("shl4",       OP_SHL,  8'h81, 8'h04, 1, 16'h0810, 0, 0, 0, 0, 0);
        run("shl7",       OP_SHL,  8'h01, 8'h07, 1, 16'h0080, 0, 0, 0, 0, 0);
        run("shr0",       OP_SHR,  8'h90, 8'h00, 1, 16'h0090, 0, 0, 0, 1, 0);
        run("shr_hi_b",   OP_SHR,  8'h90, 8'hFC, 1, 16'h0009, 0, 0, 0, 0, 0);

        // Backpressure: result holds while inputs churn and out_ready stays low
        do_op(OP_ADD, 8'h12, 8'h34);
        wait_valid(lat);
        check("bp.latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.a        = 8'(8'hA5 + i * 37);
            bus.b        = 8'(8'h3C + i * 11);
            bus.op       = 4'(i + 8);
            tick();
            check("bp.y",         32'(bus.y),         32'h0046);
            check("bp.flags",     32'({bus.zero, bus.carry, bus.ovf, bus.neg, bus.illegal}), 32'd0);
            check("bp.in_ready",  32'(bus.in_ready),  32'd0);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp.release_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp.release_out_valid", 32'(bus.out_valid), 32'd0);

        // Reset during the 4th MUL cycle aborts the multiply
        do_op(OP_MUL, 8'hFF, 8'hFF);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst.y",         32'(bus.y),         32'd0);
        check("mrst.flags",     32'({bus.zero, bus.carry, bus.ovf, bus.neg, bus.illegal}), 32'd0);
        check("mrst.in_ready",  32'(bus.in_ready),  32'd1);
        hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.out_valid === 1'b1) hits++;
        end
        check("mrst.no_result", 32'(hits), 32'd0);

        // Illegal opcodes
        run("illegal_c",  4'hC, 8'h12, 8'h34, 1, 16'h0000, 1, 0, 0, 0, 1);
        run("illegal_f",  4'hF, 8'hFF, 8'hFF, 1, 16'h0000, 1, 0, 0, 0, 1);
        run("after_ill",  OP_AND, 8'hF0, 8'h3C, 1, 16'h0030, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the 4-bit combinational ALU: WIDTH-bit operands, 4-bit opcode, and a double-width result with status flags.
Adds shifts, an iterative shift-add unsigned multiply, and valid/ready handshakes on input and output.
Sits between an operand-issue stage and a result consumer.
Accepts one operation at a time; no overlap between operations.

Parameters:
WIDTH, 8, operand width in bits (power of two, >= 4)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B (shift amount = b[log2(WIDTH)-1:0])
op  input  4  opcode
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts the result
y  output  2*WIDTH  result
zero  output  1  y == 0
carry  output  1  carry/borrow/high-half-nonzero
ovf  output  1  signed overflow
neg  output  1  sign of the result
illegal  output  1  opcode not implemented

Behaviour:
- Reset, synchronous and active-high (clk, rst):
  - State goes to IDLE; y, all flags and out_valid go to 0.
  - in_ready reads 1 the cycle after rst deasserts.
  - Reset wins over every other event, including mid-multiply: the multiply is aborted and no result is produced.
- State machine: IDLE, MUL, DONE.
  - IDLE: in_ready=1, out_valid=0. If in_valid=1:
    - op=MUL: latch a and b, clear the bit counter, go to MUL.
    - Any other op: compute, register y and flags, go to DONE.
  - MUL: in_ready=0. One shift-add step per cycle over WIDTH steps, counter 0..WIDTH-1. On the step with counter=WIDTH-1, register the product and flags and go to DONE.
  - DONE: out_valid=1; y and flags hold stable. If out_ready=1, go to IDLE.
  - in_ready=0 in DONE, including the cycle out_ready is high; the next operation is accepted one cycle later.
- Latency, counted from the accept edge:
  - Single-cycle ops: out_valid high after 1 clk.
  - MUL: out_valid high after WIDTH+1 clks.
  - Minimum issue interval is 2 cycles.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR, 8 MUL, 9 SHL, 10 SHR, 11 SAR. Codes 12-15 are illegal.
- Width rules:
  - Ops 0-7 and 10-11 produce a WIDTH-bit result in y[WIDTH-1:0]. y[2W-1:W]=0, except ADD, where y[WIDTH] = carry.
  - ADD: {carry, sum} = a + b. ovf = signed overflow.
  - SUB: a - b mod 2^W. carry = borrow (a < b unsigned). ovf = signed overflow.
  - Logic ops: carry = 0, ovf = 0.
  - MUL: unsigned 2W-bit product. carry = |y[2W-1:W]. ovf = 0.
  - SHL: y = {W'b0, a} << shamt (full 2W result, nothing lost). carry = 0, ovf = 0.
  - SHR: logical shift. SAR: arithmetic shift, sign-filled from a[W-1]. carry = 0, ovf = 0 for both.
  - Shift amount 0 passes a through unchanged.
- Flags:
  - zero = (y == 0), for all ops.
  - neg = y[WIDTH-1] for ops 0-7, 10 and 11. neg = 0 for MUL and SHL.
  - Illegal opcode: y = 0, zero = 1, carry = ovf = neg = 0, illegal = 1. Completes with single-cycle latency.
  - illegal = 0 for all legal ops.
- Operand timing: a, b and op are sampled only on the accept edge (in_valid & in_ready). Later changes to the inputs have no effect.
- in_valid while in_ready=0 is ignored, not queued. The producer must hold the request until in_ready.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_ADD..OP_SAR.
  - State encoding: S_IDLE, S_MUL, S_DONE.
  - Function clog2 for the shift-amount and counter widths.
- Sub-module alu_seq_mul: the iterative shift-add multiplier.
  - Ports: start, a, b, done, p.
  - Counter width clog2(WIDTH)+1.
- Single-cycle ops stay as a combinational case block inside alu_seq.

Test Plan:
1. WIDTH=8, ADD a=8'hF0 b=8'h20 -> one clk after accept: y=16'h0110, carry=1, ovf=0, zero=0, neg=0.
2. SUB a=8'h80 b=8'h01 -> y=16'h007F, carry=0, ovf=1, neg=0. SUB a=8'h03 b=8'h05 -> y=16'h00FE, carry=1, neg=1.
3. MUL a=8'hFF b=8'hFF -> in_ready=0 for 9 cycles; out_valid exactly 9 clks after accept; y=16'hFE01, carry=1. MUL by 0 -> y=0, zero=1.
4. SAR a=8'h90 shamt=3 -> y=16'h00F2, neg=1. SHL a=8'h81 shamt=4 -> y=16'h0810. SHR a=8'h90 shamt=0 -> y=16'h0090.
5. Backpressure: after ADD, hold out_ready=0 for 5 cycles while toggling a, b, op and in_valid -> y and flags stable, in_ready=0. Raise out_ready -> in_ready=1 on the next cycle.
6. Assert rst in the 4th MUL cycle -> next cycle out_valid=0, y=0, flags=0, in_ready=1. op=4'hC -> y=0, illegal=1, zero=1.
